hc_sr04_ctrl: RTL
=================

HC_SR04_CTRL -- requirements
Module: hc_sr04_ctrl

Interface
REQ-001 Parameter TRIG_US, default 10, trigger pulse width in 1 us ticks.
REQ-002 Parameter TIMEOUT_US, default 30000, maximum wait for echo start and maximum echo width, in ticks (must be < 65535).
REQ-003 Parameter PERIOD_US, default 60000, minimum ticks from one trigger start to the next (must be > TRIG_US + 2*TIMEOUT_US/2, and ≤ 65535).
REQ-004 Parameter US_PER_CM, default 58, echo ticks per centimetre of distance.
REQ-005 clk_50M  in  1  system clock; one clock domain, all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 tick_us  in  1  one-clk_50M-cycle strobe every 1 us, synchronous to clk_50M.
REQ-008 start  in  1  single-shot measurement request, sampled each cycle.
REQ-009 auto_en  in  1  level; when high, measurements repeat back-to-back every PERIOD_US.
REQ-010 echo  in  1  sensor echo pin, asynchronous.
REQ-011 trig  out  1  sensor trigger pin, registered.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 echo_us  out  16  last echo width in ticks.
REQ-014 dist_cm  out  10  last distance in cm.
REQ-015 valid  out  1  one-cycle pulse when echo_us/dist_cm/timeout update.
REQ-016 timeout  out  1  level; 1 if last measurement timed out, else 0.

Function
REQ-017 echo SHALL pass a 2-flop synchronizer; echo_s = second flop; edge detect uses a third registered copy; echo-to-detect latency 3 clk_50M cycles.
REQ-018 FSM states: IDLE, TRIG, WAIT_ECHO, MEASURE, HOLDOFF.
REQ-019 IDLE: start=1 or auto_en=1 -> TRIG next cycle; tick counter, period counter, cm subcounter, cm counter cleared.
REQ-020 TRIG: trig=1; period counter and trigger counter increment per tick_us; after TRIG_US ticks -> WAIT_ECHO, trig=0 in same cycle as state change.
REQ-021 WAIT_ECHO: rising edge of echo_s -> MEASURE with width counters cleared; wait counter reaching TIMEOUT_US ticks -> HOLDOFF, timeout event.
REQ-022 echo_s already high on WAIT_ECHO entry is not a rising edge; only a 0->1 transition counts (stuck-high -> timeout).
REQ-023 MEASURE: per tick_us increment width counter; cm subcounter counts to US_PER_CM-1 then wraps to 0 and increments cm counter (cm saturates at 1023).
REQ-024 MEASURE: falling edge of echo_s -> HOLDOFF; echo_us<=width, dist_cm<=cm, timeout<=0, valid=1 for one cycle.
REQ-025 MEASURE: width reaching TIMEOUT_US -> HOLDOFF, timeout event.
REQ-026 Timeout event: echo_us<=TIMEOUT_US, dist_cm<=10'h3FF, timeout<=1, valid=1 for one cycle.
REQ-027 Period counter runs from TRIG entry through HOLDOFF, one increment per tick_us in every non-IDLE state; HOLDOFF -> IDLE when it reaches PERIOD_US.
REQ-028 start while busy=1 SHALL be ignored (not queued).
REQ-029 Counters advance only on tick_us; tick_us coincident with an echo edge counts before the edge acts.
REQ-030 auto_en deasserted mid-measurement: current measurement completes through HOLDOFF, then IDLE holds.

Reset
REQ-031 rst=1 at any clock edge, including mid-measurement: state IDLE, trig=0, busy=0, valid=0, timeout=0, echo_us=0, dist_cm=0, all counters and synchronizer flops 0, from the next cycle.

Verification
REQ-032 start pulse, tick_us every 50 clks -> trig high exactly 10 ticks (500 clks), busy=1 on the cycle after start.
REQ-033 echo high 580 us after trigger -> valid pulse, echo_us=580, dist_cm=10, timeout=0; next IDLE at 60000 ticks after TRIG entry.
REQ-034 echo never rises -> after 30000 ticks in WAIT_ECHO: valid, timeout=1, echo_us=30000, dist_cm=1023.
REQ-035 echo held high before and through trigger -> timeout result as REQ-034; start during busy -> no extra trigger.
REQ-036 auto_en=1 for 3 periods with 1160 us echoes -> 3 valid pulses, dist_cm=20 each, triggers spaced exactly PERIOD_US ticks.
REQ-037 rst asserted during MEASURE -> trig=0, busy=0, outputs 0 next cycle; later start runs a clean measurement.

Source files
------------

// File: rtl/hc_sr04_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : hc_sr04_ctrl                                                   |
// | Brief   : HC-SR04 ultrasonic ranger controller (trigger, echo timing,    |
// |           distance conversion, single-shot and auto-repeat modes).       |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module hc_sr04_ctrl #(
  parameter int TRIG_US    = 10,
  parameter int TIMEOUT_US = 30000,
  parameter int PERIOD_US  = 60000,
  parameter int US_PER_CM  = 58
) (
  input  logic        clk_50M,
  input  logic        rst,
  input  logic        tick_us,
  input  logic        start,
  input  logic        auto_en,
  input  logic        echo,
  output logic        trig,
  output logic        busy,
  output logic [15:0] echo_us,
  output logic [9:0]  dist_cm,
  output logic        valid,
  output logic        timeout
);

  localparam logic [15:0] c_trig_last   = 16'(TRIG_US - 1);
  localparam logic [15:0] c_to_last     = 16'(TIMEOUT_US - 1);
  localparam logic [15:0] c_to_val      = 16'(TIMEOUT_US);
  localparam logic [15:0] c_period      = 16'(PERIOD_US);
  localparam logic [15:0] c_period_last = 16'(PERIOD_US - 1);
  localparam int          c_sub_w       = (US_PER_CM > 1) ? $clog2(US_PER_CM) : 1;
  localparam logic [c_sub_w-1:0] c_sub_last = c_sub_w'(US_PER_CM - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_TRIG = 3'd1,
    S_WAIT = 3'd2,
    S_MEAS = 3'd3,
    S_HOLD = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 r_echo_meta, r_echo_s, r_echo_d;
  logic [15:0]          r_cnt, r_period;
  logic [c_sub_w-1:0]   r_cm_sub;
  logic [9:0]           r_cm;
  logic                 r_trig, r_valid, r_timeout;
  logic [15:0]          r_echo_us;
  logic [9:0]           r_dist_cm;

  logic                 w_rise, w_fall, w_done_ok, w_done_to, w_sub_wrap;
  logic [15:0]          w_cnt_nxt;
  logic [c_sub_w-1:0]   w_sub_nxt;
  logic [9:0]           w_cm_nxt;

  assign w_rise = r_echo_s & ~r_echo_d;
  assign w_fall = ~r_echo_s & r_echo_d;

  // Counter values after this cycle's tick, so a tick coincident with an edge is counted
  assign w_cnt_nxt  = tick_us ? r_cnt + 16'd1 : r_cnt;
  assign w_sub_wrap = tick_us && (r_cm_sub == c_sub_last);
  assign w_sub_nxt  = !tick_us ? r_cm_sub : (w_sub_wrap ? '0 : r_cm_sub + 1'b1);
  assign w_cm_nxt   = (w_sub_wrap && r_cm != 10'h3FF) ? r_cm + 10'd1 : r_cm;

  always_comb begin
    w_next    = r_state;
    w_done_ok = 1'b0;
    w_done_to = 1'b0;
    case (r_state)
      S_IDLE: if (start || auto_en) w_next = S_TRIG;
      S_TRIG: if (tick_us && r_cnt >= c_trig_last) w_next = S_WAIT;
      S_WAIT: begin
        if (tick_us && r_cnt >= c_to_last) begin
          w_next    = S_HOLD;
          w_done_to = 1'b1;
        end else if (w_rise) begin
          w_next = S_MEAS;
        end
      end
      S_MEAS: begin
        if (tick_us && r_cnt >= c_to_last) begin
          w_next    = S_HOLD;
          w_done_to = 1'b1;
        end else if (w_fall) begin
          w_next    = S_HOLD;
          w_done_ok = 1'b1;
        end
      end
      S_HOLD: begin
        // A worst-case measurement may already have used up the whole period
        if (r_period >= c_period || (tick_us && r_period >= c_period_last))
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_echo_meta <= 1'b0;
      r_echo_s    <= 1'b0;
      r_echo_d    <= 1'b0;
      r_cnt       <= '0;
      r_period    <= '0;
      r_cm_sub    <= '0;
      r_cm        <= '0;
      r_trig      <= 1'b0;
      r_valid     <= 1'b0;
      r_timeout   <= 1'b0;
      r_echo_us   <= '0;
      r_dist_cm   <= '0;
    end else begin
      r_echo_meta <= echo;
      r_echo_s    <= r_echo_meta;
      r_echo_d    <= r_echo_s;
      r_state     <= w_next;
      r_trig      <= (w_next == S_TRIG);
      r_valid     <= w_done_ok | w_done_to;

      if (w_done_to) begin
        r_echo_us <= c_to_val;
        r_dist_cm <= 10'h3FF;
        r_timeout <= 1'b1;
      end else if (w_done_ok) begin
        r_echo_us <= w_cnt_nxt;
        r_dist_cm <= w_cm_nxt;
        r_timeout <= 1'b0;
      end

      if (r_state == S_IDLE) begin
        r_cnt    <= '0;
        r_period <= '0;
        r_cm_sub <= '0;
        r_cm     <= '0;
      end else begin
        if (tick_us && r_period != 16'hFFFF) r_period <= r_period + 16'd1;
        if (w_next != r_state) begin
          r_cnt    <= '0;
          r_cm_sub <= '0;
          r_cm     <= '0;
        end else if (r_state == S_MEAS) begin
          r_cnt    <= w_cnt_nxt;
          r_cm_sub <= w_sub_nxt;
          r_cm     <= w_cm_nxt;
        end else if (r_state != S_HOLD) begin
          r_cnt <= w_cnt_nxt;
        end
      end
    end
  end

  assign trig    = r_trig;
  assign busy    = (r_state != S_IDLE);
  assign echo_us = r_echo_us;
  assign dist_cm = r_dist_cm;
  assign valid   = r_valid;
  assign timeout = r_timeout;

endmodule
`default_nettype wire
